bit_serializer: RTL and testbench
=================================

Name: bit_serializer

Overview:
Parallel-in, serial-out stage that feeds the serial bit-pattern FSM's `in` input, one bit per clock, MSB first. Accepts WIDTH-bit words over a valid/ready handshake. Drives a line that idles low, so the downstream detector sees zeros between words. An optional inter-word gap sets the framing of the serial stream.

Parameters:
WIDTH, 8, word width in bits; must be at least 2.
GAP, 0, number of idle (ser_valid=0, ser_out=0) cycles forced between consecutive words; must be at least 0.

Ports:
clk  input  1  clock, rising-edge.
reset  input  1  asynchronous, active-high reset.
data_in  input  WIDTH  parallel word; sampled only on an accept edge.
data_valid  input  1  upstream has a word.
data_ready  output  1  block can accept a word this cycle.
ser_out  output  1  serial bit to the pattern FSM; 0 whenever ser_valid=0.
ser_valid  output  1  ser_out carries a data (or parity) bit.
busy  output  1  block is in any state other than IDLE.
word_done  output  1  high during the final bit cycle of a word.

Behaviour:
- Reset is asynchronous and active-high. While it is applied: state=IDLE, shift register=0, bit and gap counters=0, ser_out=0, ser_valid=0, busy=0, word_done=0, data_ready=1.
- Reset mid-word aborts the word. Outputs drop to their reset values immediately, the partial word is discarded and never resumed.
- Accept condition: data_valid && data_ready at a rising edge. On accept, load the shift register from data_in, set bit counter=WIDTH-1, enter SHIFT.
- data_valid while data_ready=0 is ignored; data_in is not sampled.
- SHIFT state:
  - ser_valid=1 and ser_out=shreg[WIDTH-1].
  - Each edge shifts left by one and decrements the counter.
  - The last bit is the cycle with counter==0.
- Latency: accept at edge N puts the MSB on ser_out in cycle N+1 and the LSB in cycle N+WIDTH.
- word_done=1 in exactly one cycle per word: the LSB cycle, or the parity cycle when SER_PARITY_EN is defined.
- Leaving the final bit cycle:
  - GAP=0: go to IDLE. If an accept occurs on this same edge, load the new word and stay in SHIFT.
  - GAP>0: go to GAP state with gap counter=GAP-1.
- GAP state: ser_valid=0, ser_out=0. The counter decrements each edge; when it reaches 0, exit to IDLE, or to SHIFT if an accept occurs on that edge.
- data_ready is asserted in three cases:
  - state is IDLE;
  - final bit cycle with GAP=0;
  - final GAP cycle.
- Net effect: back-to-back words are separated by exactly GAP invalid cycles.
- Counter widths: $clog2(WIDTH) for the bit counter, $clog2(GAP+1) for the gap counter (minimum 1). No wrap-around is permitted: each counter is reloaded before it underflows.
- busy=1 in SHIFT, PAR and GAP; busy=0 in IDLE.

Optional Feature:
SER_PARITY_EN
- Defined: after the LSB, the block spends one extra PAR cycle with ser_valid=1 and ser_out = XOR of the accepted word (even parity). word_done and the data_ready/GAP transition move to the PAR cycle. Each word occupies WIDTH+1 cycles.
- Undefined: there is no PAR state, each word occupies WIDTH cycles, and no parity logic is synthesised.

Decomposition:
- Shared package ser_pkg holds:
  - the state typedef: IDLE, SHIFT, PAR, GAP, 2-bit encoding;
  - the constant SER_IDLE_LEVEL = 1'b0.
- One natural sub-module: ser_down_counter, a loadable down-counter with a zero flag and a WIDTH parameter. It is instantiated twice, once for bits and once for the gap.

Test Plan:
- WIDTH=8, GAP=0, send 8'hB5 -> ser_out 1,0,1,1,0,1,0,1 in cycles N+1..N+8. ser_valid high for those 8 cycles. word_done only in cycle N+8. busy back to 0 in N+9.
- GAP=0, data_valid held high with 8'hFF then 8'h00 -> 16 contiguous ser_valid cycles: eight 1s then eight 0s. data_ready pulses in cycle N+8.
- GAP=2, two back-to-back words -> exactly 2 cycles of ser_valid=0, ser_out=0 between the LSB of word 1 and the MSB of word 2.
- Apply reset during the 4th bit of 8'hF0 -> ser_valid, ser_out and busy go to 0 asynchronously. After release, data_ready=1 and the next word 8'h81 serialises correctly from its MSB.
- data_valid pulsed with 8'h3C while busy -> word ignored. Only the in-flight word appears on ser_out.
- SER_PARITY_EN defined, send 8'hB5 (popcount 5) -> cycle N+9 has ser_valid=1, ser_out=1 and word_done=1.

Source files
------------

// File: rtl/ser_pkg.sv
// Shared state encoding and line constants for the bit serializer.
// The SER_PARITY_EN option is resolved in bit_serializer; this package is option-independent.
package ser_pkg;

  typedef logic [1:0] ser_state_t;

  localparam ser_state_t ST_IDLE  = 2'd0;
  localparam ser_state_t ST_SHIFT = 2'd1;
  localparam ser_state_t ST_PAR   = 2'd2;
  localparam ser_state_t ST_GAP   = 2'd3;

  // Level the serial line rests at between words; the downstream detector sees zeros.
  localparam logic SER_IDLE_LEVEL = 1'b0;

endpackage

// File: rtl/ser_down_counter.sv
// Loadable down-counter with a zero flag.
// The count saturates at zero: a decrement request at zero has no effect.
module ser_down_counter #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             dec,
  output logic             zero
);

  logic [WIDTH-1:0] count;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (dec && (count != '0)) begin
      count <= count - WIDTH'(1);
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/bit_serializer.sv
// Parallel-in, serial-out stage, MSB first, with optional inter-word idle gap.
// Define SER_PARITY_EN to append an even-parity bit after each word's LSB.
//
// state | meaning
// IDLE  | no word in flight, ready for a new word
// SHIFT | driving data bits, MSB first
// PAR   | driving the parity bit (SER_PARITY_EN only)
// GAP   | forced idle cycles between words
module bit_serializer
  import ser_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int GAP   = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] data_in,
  input  logic             data_valid,
  output logic             data_ready,
  output logic             ser_out,
  output logic             ser_valid,
  output logic             busy,
  output logic             word_done
);

  localparam int BCW     = $clog2(WIDTH);
  localparam int GCW     = (GAP > 0) ? $clog2(GAP + 1) : 1;
  localparam bit HAS_GAP = (GAP > 0);

  localparam logic [BCW-1:0] BIT_LOAD = BCW'(WIDTH - 1);
  localparam logic [GCW-1:0] GAP_LOAD = GCW'((GAP > 0) ? (GAP - 1) : 0);

  ser_state_t       state;
  ser_state_t       state_nxt;
  ser_state_t       after_word;
  ser_state_t       word_exit;
  logic [WIDTH-1:0] shreg;
  logic             bit_zero;
  logic             gap_zero;
  logic             last_bit;
  logic             final_cycle;
  logic             gap_last;
  logic             accept;
  logic             bit_dec;
  logic             gap_load;
  logic             gap_dec;

`ifdef SER_PARITY_EN
  logic parity;
`endif

  assign last_bit = (state == ST_SHIFT) && bit_zero;
  assign gap_last = (state == ST_GAP) && gap_zero;

`ifdef SER_PARITY_EN
  assign final_cycle = (state == ST_PAR);
`else
  assign final_cycle = last_bit;
`endif

  // Ready opens only on the cycle whose following edge can start a new word,
  // which keeps consecutive words exactly GAP idle cycles apart.
  assign data_ready = (state == ST_IDLE)
                    || (final_cycle && !HAS_GAP)
                    || gap_last;
  assign accept     = data_valid && data_ready;

  assign bit_dec  = (state == ST_SHIFT) && !bit_zero;
  assign gap_load = final_cycle && HAS_GAP;
  assign gap_dec  = (state == ST_GAP) && !gap_zero;

  ser_down_counter #(
    .WIDTH(BCW)
  ) u_bit_cnt (
    .clk      (clk),
    .reset    (reset),
    .load     (accept),
    .load_val (BIT_LOAD),
    .dec      (bit_dec),
    .zero     (bit_zero)
  );

  ser_down_counter #(
    .WIDTH(GCW)
  ) u_gap_cnt (
    .clk      (clk),
    .reset    (reset),
    .load     (gap_load),
    .load_val (GAP_LOAD),
    .dec      (gap_dec),
    .zero     (gap_zero)
  );

  assign after_word = accept ? ST_SHIFT : ST_IDLE;
  assign word_exit  = HAS_GAP ? ST_GAP : after_word;

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        state_nxt = after_word;
      end
      ST_SHIFT: begin
        if (bit_zero) begin
`ifdef SER_PARITY_EN
          state_nxt = ST_PAR;
`else
          state_nxt = word_exit;
`endif
        end
      end
`ifdef SER_PARITY_EN
      ST_PAR: begin
        state_nxt = word_exit;
      end
`endif
      ST_GAP: begin
        if (gap_zero) begin
          state_nxt = after_word;
        end
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= ST_IDLE;
      shreg <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        shreg <= data_in;
      end else if (state == ST_SHIFT) begin
        shreg <= {shreg[WIDTH-2:0], 1'b0};
      end
    end
  end

`ifdef SER_PARITY_EN
  // Parity is taken from the accepted word, since the shift register is consumed by then.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      parity <= 1'b0;
    end else if (accept) begin
      parity <= ^data_in;
    end
  end
`endif

  always_comb begin
    ser_valid = 1'b0;
    ser_out   = SER_IDLE_LEVEL;
    case (state)
      ST_SHIFT: begin
        ser_valid = 1'b1;
        ser_out   = shreg[WIDTH-1];
      end
`ifdef SER_PARITY_EN
      ST_PAR: begin
        ser_valid = 1'b1;
        ser_out   = parity;
      end
`endif
      default: begin
        ser_valid = 1'b0;
        ser_out   = SER_IDLE_LEVEL;
      end
    endcase
  end

  assign busy      = (state != ST_IDLE);
  assign word_done = final_cycle;

endmodule

// File: tb/tb_bit_serializer.sv
// Bench for bit_serializer: GAP=0 and GAP=2 instances share stimulus and are
// checked every cycle against a per-cycle expected-output queue, plus literal checks.
module tb_bit_serializer;

  localparam int W = 8;
`ifdef SER_PARITY_EN
  localparam int PAR = 1;
`else
  localparam int PAR = 0;
`endif
  localparam int FL = W + PAR;

  logic         clk = 1'b0;
  logic         reset;
  logic         data_valid = 1'b0;
  logic [W-1:0] data_in = '0;

  logic r0, o0, v0, b0, d0;
  logic r2, o2, v2, b2, d2;

  int vectors = 0;
  int miscompares = 0;
  bit started = 1'b0;

  // Expected per-cycle outputs {valid, out, done}; head is the current cycle.
  logic [2:0] q0[$];
  logic [2:0] q2[$];

  logic [W-1:0] cap;
  logic [31:0]  sb;
  logic [31:0]  rhist;
  logic [63:0]  vhist;
  int           vcnt, dpos, z, s;

  bit_serializer #(.WIDTH(W), .GAP(0)) u0 (
    .clk(clk), .reset(reset), .data_in(data_in), .data_valid(data_valid),
    .data_ready(r0), .ser_out(o0), .ser_valid(v0), .busy(b0), .word_done(d0)
  );

  bit_serializer #(.WIDTH(W), .GAP(2)) u2 (
    .clk(clk), .reset(reset), .data_in(data_in), .data_valid(data_valid),
    .data_ready(r2), .ser_out(o2), .ser_valid(v2), .busy(b2), .word_done(d2)
  );

  always #5 clk = ~clk;

  function automatic logic [2:0] item_at(logic [W-1:0] w, int idx);
    if (idx < W) return {1'b1, w[W-1-idx], ((idx == W-1) && (PAR == 0))};
    if ((PAR == 1) && (idx == W)) return {1'b1, ^w, 1'b1};
    return 3'b000;
  endfunction

  function automatic logic [4:0] exp_of(logic [2:0] head, int n);
    return {head, (n != 0), (n <= 1)};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, req, $time);
    end
  endtask

  always @(posedge clk) begin : model_upd
    bit a0, a2;
    if (!reset) begin
      a0 = data_valid && (q0.size() <= 1);
      a2 = data_valid && (q2.size() <= 1);
      if (q0.size() != 0) void'(q0.pop_front());
      if (q2.size() != 0) void'(q2.pop_front());
      if (a0) for (int i = 0; i < FL; i++) q0.push_back(item_at(data_in, i));
      if (a2) for (int i = 0; i < FL + 2; i++) q2.push_back(item_at(data_in, i));
    end
  end

  always @(negedge clk) begin
    if (started && !reset) begin
      check("u0_outputs", 32'({v0, o0, d0, b0, r0}),
            32'(exp_of((q0.size() != 0) ? q0[0] : 3'b000, q0.size())));
      check("u2_outputs", 32'({v2, o2, d2, b2, r2}),
            32'(exp_of((q2.size() != 0) ? q2[0] : 3'b000, q2.size())));
    end
  end

  task automatic wait_idle();
    for (int i = 0; i < 100 && (b0 || b2); i++) @(negedge clk);
    check("idle_timeout", 32'({b0, b2}), 32'd0);
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    q0.delete();
    q2.delete();
  endtask

  initial begin
    reset = 1'b1;
    #12;
    check("reset_u0", 32'({v0, o0, d0, b0, r0}), 32'b00001);
    check("reset_u2", 32'({v2, o2, d2, b2, r2}), 32'b00001);
    #11 reset = 1'b0;
    started = 1'b1;

    // Single word 8'hB5 on the GAP=0 instance.
    @(negedge clk);
    wait_idle();
    @(posedge clk); #1 data_valid = 1'b1; data_in = 8'hB5;
    @(posedge clk); #1 data_valid = 1'b0;
    cap = '0; vcnt = 0; dpos = 0;
    for (int i = 1; i <= W; i++) begin
      @(negedge clk);
      cap = {cap[W-2:0], o0};
      vcnt += int'(v0);
      if (d0) dpos = i;
    end
    check("b5_bits", 32'(cap), 32'h0000_00B5);
    check("b5_valid_cycles", 32'(vcnt), 32'd8);
    @(negedge clk);
`ifdef SER_PARITY_EN
    check("b5_done_in_data", 32'(dpos), 32'd0);
    check("b5_parity_cycle", 32'({v0, o0, d0}), 32'b111);
`else
    check("b5_done_pos", 32'(dpos), 32'd8);
    check("b5_idle_after", 32'({b0, v0, d0}), 32'd0);
`endif

    // 8'hFF then 8'h00 with data_valid held.
    wait_idle();
    @(posedge clk); #1 data_valid = 1'b1; data_in = 8'hFF;
    @(posedge clk); #1 data_in = 8'h00;
    rhist = '0; vhist = '0; sb = '0;
    for (int i = 1; i <= 30; i++) begin
      @(negedge clk);
      vhist[i] = v0;
      if (v0) sb = {sb[30:0], o0};
      if (i <= FL) rhist[i] = r0;
      if (i == FL) begin
        @(posedge clk); #1 data_valid = 1'b0;
      end
    end
    check("ff00_ready_pulse", rhist, 32'd1 << FL);
    check("ff00_contiguous", vhist[31:0], 32'(((64'd1 << (2 * FL)) - 64'd1) << 1));
`ifdef SER_PARITY_EN
    check("ff00_stream", sb, 32'h0003_FC00);
`else
    check("ff00_stream", sb, 32'h0000_FF00);
`endif

    // Back-to-back words on the GAP=2 instance.
    wait_idle();
    @(posedge clk); #1 data_valid = 1'b1; data_in = 8'hC3;
    @(posedge clk); #1 data_in = 8'h5A;
    vhist = '0;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      vhist[i] = v2;
      if (i == FL + 2) begin
        check("gap_ready_final_gap", 32'(r2), 32'd1);
        @(posedge clk); #1 data_valid = 1'b0;
      end
    end
    z = 0; s = 0;
    for (int i = 2; i <= 40; i++) begin
      if (z == 0 && vhist[i-1] && !vhist[i]) z = i;
      else if (z != 0 && s == 0 && vhist[i]) s = i;
    end
    check("gap_len", 32'(s - z), 32'd2);
    check("gap_second_msb_cycle", 32'(s), 32'(FL + 3));

    // Reset during the 4th bit of 8'hF0, then 8'h81.
    wait_idle();
    @(posedge clk); #1 data_valid = 1'b1; data_in = 8'hF0;
    @(posedge clk); #1 data_valid = 1'b0;
    repeat (4) @(negedge clk);
    check("f0_bit4", 32'({v0, o0, b0}), 32'b111);
    #2 pulse_reset();
    #1 check("reset_async_u0", 32'({v0, o0, b0, d0, r0}), 32'b00001);
    check("reset_async_u2", 32'({v2, o2, b2, d2, r2}), 32'b00001);
    #1 reset = 1'b0;
    @(posedge clk); #1 data_valid = 1'b1; data_in = 8'h81;
    @(posedge clk); #1 data_valid = 1'b0;
    cap = '0;
    for (int i = 1; i <= W; i++) begin
      @(negedge clk);
      cap = {cap[W-2:0], o0};
    end
    check("after_reset_81", 32'(cap), 32'h0000_0081);

    // 8'h3C offered while busy must be ignored.
    wait_idle();
    @(posedge clk); #1 data_valid = 1'b1; data_in = 8'hA5;
    @(posedge clk); #1 data_valid = 1'b0;
    cap = '0; vcnt = 0;
    for (int i = 1; i <= 24; i++) begin
      @(negedge clk);
      if (v0) begin
        if (vcnt < W) cap = {cap[W-2:0], o0};
        vcnt++;
      end
      if (i == 3) begin
        @(posedge clk); #1 data_valid = 1'b1; data_in = 8'h3C;
      end
      if (i == 4) begin
        @(posedge clk); #1 data_valid = 1'b0;
      end
    end
    check("busy_ignore_bits", 32'(cap), 32'h0000_00A5);
    check("busy_ignore_count", 32'(vcnt), 32'(FL));

    // Randomized traffic with occasional asynchronous resets.
    for (int n = 0; n < 600; n++) begin
      @(posedge clk);
      #1 data_valid = ($urandom_range(0, 99) < 55);
      data_in = W'($urandom);
      if ($urandom_range(0, 249) == 0) begin
        #2 pulse_reset();
        #3 reset = 1'b0;
      end
    end
    #1 data_valid = 1'b0;
    @(negedge clk);
    wait_idle();
    @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
